// File: rtl/aes_decrypt_iter_pkg.sv
// ============================================================================
//  Module  : aes_decrypt_iter_pkg
//  Brief   : Shared AES tables, FSM encodings and byte/word helpers for the
//            iterative AES-128 decryption core.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package aes_decrypt_iter_pkg;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_KEYEXP = 2'd1;
    localparam logic [1:0] C_ST_DEC    = 2'd2;
    localparam logic [1:0] C_ST_DONE   = 2'd3;

    localparam logic [0:255][7:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f6648668981664a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return C_SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return C_INV_SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies by 0e/0b/0d/09 are built from the x2/x4/x8 ladder.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]  ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_decrypt_iter_inv_round.sv
// ============================================================================
//  Module  : aes_decrypt_iter_inv_round
//  Brief   : Combinational AES inverse round: InvShiftRows, InvSubBytes,
//            AddRoundKey and InvMixColumns with a final-round bypass.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module aes_decrypt_iter_inv_round
    import aes_decrypt_iter_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] w_shifted;
    logic [127:0] w_subbed;
    logic [127:0] w_added;
    logic [127:0] w_mixed;

    // Byte (row r, column c) sits at index 4c+r; row r rotates right by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shifted[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c+4-r)%4)+r) -: 8];
        end
    end

    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign w_subbed[127-8*b -: 8] = inv_sbox(w_shifted[127-8*b -: 8]);
    end

    assign w_added = w_subbed ^ rkey_i;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mixed[127-32*c -: 32] = inv_mix_col(w_added[127-32*c -: 32]);
    end

    assign state_o = last_i ? w_added : w_mixed;

endmodule

`default_nettype wire

// File: rtl/aes_decrypt_iter.sv
// ============================================================================
//  Module  : aes_decrypt_iter
//  Brief   : Iterative AES-128 decryption core, one inverse round per clock,
//            with valid/ready handshakes on both sides.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module aes_decrypt_iter
    import aes_decrypt_iter_pkg::*;
#(
    parameter logic [3:0] FINAL_ROUND = 4'ha,
    parameter bit         KEY_IS_LAST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] pt_q, pt_d;
    logic         ov_q, ov_d;

    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;
    logic [127:0] w_round_out;

    assign w_fwd_key = fwd_key_step(key_q, rcon(rnd_q + 4'd1));
    assign w_inv_key = inv_key_step(key_q, rcon(rnd_q));

    aes_decrypt_iter_inv_round u_inv_round (
        .state_i (state_q),
        .rkey_i  (w_inv_key),
        .last_i  (rnd_q == 4'd1),
        .state_o (w_round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
        ov_d    = ov_q;
        case (fsm_q)
            C_ST_IDLE: begin
                if (in_valid) begin
                    key_d = key;
                    if (KEY_IS_LAST) begin
                        state_d = ciphertext ^ key;
                        rnd_d   = FINAL_ROUND;
                        fsm_d   = C_ST_DEC;
                    end else begin
                        state_d = ciphertext;
                        rnd_d   = 4'd0;
                        fsm_d   = C_ST_KEYEXP;
                    end
                end
            end
            C_ST_KEYEXP: begin
                if (rnd_q >= FINAL_ROUND) begin
                    fsm_d = C_ST_IDLE;
                end else begin
                    key_d = w_fwd_key;
                    rnd_d = rnd_q + 4'd1;
                    // The initial AddRoundKey uses the freshly produced last key.
                    if (rnd_q + 4'd1 == FINAL_ROUND) begin
                        state_d = state_q ^ w_fwd_key;
                        fsm_d   = C_ST_DEC;
                    end
                end
            end
            C_ST_DEC: begin
                if (rnd_q == 4'd0 || rnd_q > FINAL_ROUND) begin
                    fsm_d = C_ST_IDLE;
                end else begin
                    key_d = w_inv_key;
                    rnd_d = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        pt_d  = w_round_out;
                        ov_d  = 1'b1;
                        fsm_d = C_ST_DONE;
                    end else begin
                        state_d = w_round_out;
                    end
                end
            end
            C_ST_DONE: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = C_ST_IDLE;
                end
            end
            default: begin
                ov_d  = 1'b0;
                fsm_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= C_ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            pt_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (fsm_q == C_ST_IDLE);
    assign busy      = (fsm_q == C_ST_KEYEXP) || (fsm_q == C_ST_DEC);
    assign out_valid = ov_q;
    assign plaintext = pt_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
// ============================================================================
//  Module  : tb_aes_decrypt_iter
//  Brief   : Directed self-checking bench for aes_decrypt_iter using FIPS-197
//            vectors, backpressure, mid-operation reset and back-to-back traffic.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_decrypt_iter;

    localparam logic [127:0] C_K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext;
    logic         busy;

    logic         kl_in_valid = 1'b0;
    logic         kl_in_ready;
    logic         kl_out_valid;
    logic [127:0] kl_plaintext;
    logic         kl_busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    aes_decrypt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    aes_decrypt_iter #(.FINAL_ROUND(4'ha), .KEY_IS_LAST(1'b1)) dut_kl (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (kl_in_valid),
        .in_ready   (kl_in_ready),
        .ciphertext (C_CT_B),
        .key        (C_K10_B),
        .out_valid  (kl_out_valid),
        .out_ready  (1'b1),
        .plaintext  (kl_plaintext),
        .busy       (kl_busy)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] k);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check1("accept_busy", busy, 1'b1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [127:0] cts [3];
        logic [127:0] keys [3];
        logic [127:0] pts [3];

        repeat (2) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check128("rst_plaintext", plaintext, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 C.1
        send(C_CT_C1, C_K_C1);
        wait_done(lat);
        checkint("c1_latency", lat, 20);
        check128("c1_plaintext", plaintext, C_PT_C1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check1("c1_ret_in_ready", in_ready, 1'b1);
        check1("c1_ret_out_valid", out_valid, 1'b0);

        // FIPS-197 B, then hold the result under backpressure
        send(C_CT_B, C_K_B);
        wait_done(lat);
        checkint("b_latency", lat, 20);
        check128("b_plaintext", plaintext, C_PT_B);
        for (int i = 0; i < 5; i++) begin
            in_valid   = ~in_valid;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check128("bp_plaintext", plaintext, C_PT_B);
            check1("bp_in_ready", in_ready, 1'b0);
            check1("bp_out_valid", out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check1("bp_no_overlap", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check1("bp_in_ready_after", in_ready, 1'b1);
        check1("bp_no_accept", busy, 1'b0);

        // Reset while decrypting round 5
        send(C_CT_C1, C_K_C1);
        repeat (15) @(posedge clk);
        #2;
        check1("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check1("mid_rst_in_ready", in_ready, 1'b1);
        check128("mid_rst_plaintext", plaintext, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("post_rst_no_valid", out_valid, 1'b0);
        send(C_CT_C1, C_K_C1);
        wait_done(lat);
        checkint("post_rst_latency", lat, 20);
        check128("post_rst_plaintext", plaintext, C_PT_C1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // KEY_IS_LAST variant: starts from K10, no key expansion
        kl_in_valid = 1'b1;
        @(posedge clk);
        #1;
        kl_in_valid = 1'b0;
        check1("kl_accept_busy", kl_busy, 1'b1);
        lat = 0;
        while (!kl_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkint("kl_latency", lat, 10);
        check128("kl_plaintext", kl_plaintext, C_PT_B);

        // Back-to-back with in_valid and out_ready held high
        cts[0] = C_CT_C1; keys[0] = C_K_C1; pts[0] = C_PT_C1;
        cts[1] = C_CT_B;  keys[1] = C_K_B;  pts[1] = C_PT_B;
        cts[2] = C_CT_C1; keys[2] = C_K_C1; pts[2] = C_PT_C1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ciphertext = cts[i];
            key        = keys[i];
            @(posedge clk);
            #1;
            check1("b2b_accept", busy, 1'b1);
            if (i == 2) in_valid = 1'b0;
            wait_done(lat);
            checkint("b2b_latency", lat, 20);
            check128("b2b_plaintext", plaintext, pts[i]);
            @(posedge clk);
            #1;
            check1("b2b_idle_in_ready", in_ready, 1'b1);
            check1("b2b_idle_out_valid", out_valid, 1'b0);
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check1("end_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
